// File: rtl/mm_fill_responder_pkg.sv
// Shared widths, one-hot state encoding and index-width helper for the
// main-memory line-fill responder.
package mm_fill_responder_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_BURST = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  // Word-index width within a line; LINE_WORDS is a power of two >= 2.
  function automatic int idx_width(input int words);
    return $clog2(words);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_LINE_WORDS);

endpackage

// File: rtl/mm_array.sv
// Backing store: one synchronous write port and one synchronous read port.
// A read and write of the same word on one edge returns the old contents.
module mm_array #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rd_data;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its last word when not enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= {DW{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mm_fill_responder.sv
// Main-memory responder: fixed latency, one-line burst (one word per cycle),
// then a one-cycle we strobe that releases the cache controller.
module mm_fill_responder
  import mm_fill_responder_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int WORD_W     = DEF_WORD_W,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  parameter  int LATENCY    = DEF_LATENCY,
  localparam int IDX_W      = idx_width(LINE_WORDS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_req_addr,
  output logic                    o_busy,
  output logic                    o_fill_valid,
  output logic [IDX_W-1:0]        o_fill_idx,
  output logic [WORD_W-1:0]       o_fill_data,
  output logic                    o_we,
  input  logic                    i_wr_en,
  input  logic [ADDR_W+IDX_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0]       i_wr_data,
  output logic [3:0]              o_state
);

  localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_line, w_line_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_issued, w_issued_nxt;

  logic                r_busy, r_fill_valid, r_we;
  logic [IDX_W-1:0]    r_fill_idx;
  logic                w_valid_nxt, w_we_nxt, w_rd_en;
  logic [IDX_W-1:0]    w_fill_idx_nxt;
  logic [WORD_W-1:0]   w_rd_data;

  // State, latched line address and the latency / word counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_line   <= {ADDR_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_issued <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_line   <= w_line_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_issued <= w_issued_nxt;
    end
  end

  // Next-state and next-output decode. The first BURST cycle only launches
  // the read; r_issued marks that the last word has left for the outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_line_nxt     = r_line;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_issued_nxt   = r_issued;
    w_valid_nxt    = 1'b0;
    w_fill_idx_nxt = {IDX_W{1'b0}};
    w_we_nxt       = 1'b0;
    w_rd_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_line_nxt  = i_req_addr;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_idx_nxt    = {IDX_W{1'b0}};
          w_issued_nxt = 1'b0;
          w_state_nxt  = S_BURST;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_BURST: begin
        if (r_issued) begin
          w_we_nxt    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_rd_en        = 1'b1;
          w_valid_nxt    = 1'b1;
          w_fill_idx_nxt = r_idx;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt    = {IDX_W{1'b0}};
            w_issued_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output registers, loaded from the decoded next values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy       <= 1'b0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= {IDX_W{1'b0}};
      r_we         <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_fill_valid <= w_valid_nxt;
      r_fill_idx   <= w_fill_idx_nxt;
      r_we         <= w_we_nxt;
    end
  end

  mm_array #(
    .AW (ADDR_W + IDX_W),
    .DW (WORD_W)
  ) u_array (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_line, r_idx}),
    .o_rd_data (w_rd_data)
  );

  assign o_busy       = r_busy;
  assign o_fill_valid = r_fill_valid;
  assign o_fill_idx   = r_fill_idx;
  assign o_fill_data  = w_rd_data;
  assign o_we         = r_we;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mm_fill_responder.sv
// Self-checking bench: timeline reference model of each accepted request,
// directed scenarios with literal expectations, then random traffic.
module tb_mm_fill_responder;

  localparam int AW  = 4;
  localparam int WW  = 8;
  localparam int LW  = 4;
  localparam int LAT = 3;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW+IW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          busy, fill_valid, we;
  logic [IW-1:0] fill_idx;
  logic [WW-1:0] fill_data;
  logic [3:0]    state;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: memory image plus edges elapsed since acceptance.
  logic [WW-1:0] m_mem [0:(1<<(AW+IW))-1];
  logic [AW-1:0] m_line;
  int            m_k = -1;
  logic          e_busy = 1'b0, e_valid = 1'b0, e_we = 1'b0;
  logic [3:0]    e_state = 4'b0001;
  logic [IW-1:0] e_idx = '0;
  logic [WW-1:0] e_data = '0;

  mm_fill_responder #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_addr(req_addr),
    .o_busy(busy), .o_fill_valid(fill_valid), .o_fill_idx(fill_idx),
    .o_fill_data(fill_data), .o_we(we), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_k = -1;
        e_busy = 1'b0; e_valid = 1'b0; e_we = 1'b0;
        e_state = 4'b0001; e_idx = '0; e_data = '0;
      end else begin
        if (m_k < 0) begin
          if (req) begin
            m_line = req_addr;
            m_k = 0;
          end
        end else if (m_k == LAT + LW + 1) begin
          m_k = -1;
        end else begin
          m_k++;
        end
        e_busy  = (m_k >= 0);
        e_valid = (m_k >= LAT + 1) && (m_k <= LAT + LW);
        e_we    = (m_k == LAT + LW + 1);
        if (m_k < 0)             e_state = 4'b0001;
        else if (m_k < LAT)      e_state = 4'b0010;
        else if (m_k <= LAT + LW) e_state = 4'b0100;
        else                     e_state = 4'b1000;
        if (e_valid) begin
          e_idx  = IW'(m_k - LAT - 1);
          e_data = m_mem[{m_line, e_idx}];
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_busy", busy, e_busy);
        chk("cyc_state", state, e_state);
        chk("cyc_valid", fill_valid, e_valid);
        chk("cyc_we", we, e_we);
        if (e_valid) begin
          chk("cyc_idx", fill_idx, e_idx);
          chk("cyc_data", fill_data, e_data);
        end
      end
    end
  end

  initial begin
    int wecnt;
    logic [AW-1:0] ln;
    // Asynchronous reset between clock edges.
    #7 rst = 1'b1;
    #1;
    chk("rst_state", state, 4'b0001);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", fill_valid, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_data", fill_data, 8'h00);
    chk("rst_idx", fill_idx, 2'd0);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("idle_state", state, 4'b0001);

    for (int w = 0; w < (1 << (AW + IW)); w++) begin
      ln = AW'(w >> IW);
      wr_en = 1'b1;
      wr_addr = (AW+IW)'(w);
      case (ln)
        4'd3:    wr_data = 8'h30 + WW'(w & 3);
        4'd5:    wr_data = 8'h50 + WW'(w & 3);
        4'd7:    wr_data = 8'h70 + WW'(w & 3);
        4'd15:   wr_data = 8'hF0 + WW'(w & 3);
        default: wr_data = WW'($urandom_range(0, 255));
      endcase
      cyc(1);
    end
    wr_en = 1'b0;

    // Basic fill of line 5.
    req = 1'b1; req_addr = 4'd5;
    cyc(1);
    req = 1'b0;
    chk("bf_busy", busy, 1'b1);
    chk("bf_wait", state, 4'b0010);
    cyc(4);
    for (int i = 0; i < LW; i++) begin
      chk("bf_valid", fill_valid, 1'b1);
      chk("bf_idx", fill_idx, 32'(i));
      chk("bf_data", fill_data, 32'h50 + 32'(i));
      cyc(1);
    end
    chk("bf_we", we, 1'b1);
    chk("bf_done", state, 4'b1000);
    chk("bf_novalid", fill_valid, 1'b0);
    cyc(1);
    chk("bf_idle", state, 4'b0001);
    chk("bf_we_off", we, 1'b0);
    chk("bf_busy_off", busy, 1'b0);

    // Request held through a burst; address changes are ignored until IDLE.
    req = 1'b1; req_addr = 4'd5;
    cyc(1);
    req_addr = 4'd2;
    cyc(2);
    req_addr = 4'd7;
    cyc(2);
    chk("b2b_first", fill_data, 8'h50);
    cyc(6);
    req = 1'b0;
    cyc(4);
    chk("b2b_second", fill_data, 8'h70);
    chk("b2b_valid", fill_valid, 1'b1);
    cyc(5);
    chk("b2b_idle", state, 4'b0001);

    // Write collisions during a line-3 burst.
    req = 1'b1; req_addr = 4'd3;
    cyc(1);
    req = 1'b0;
    cyc(4);
    wr_en = 1'b1; wr_addr = {4'd3, 2'd3}; wr_data = 8'hBB;
    cyc(1);
    wr_addr = {4'd3, 2'd2}; wr_data = 8'hAA;
    cyc(1);
    wr_en = 1'b0;
    chk("col_old", fill_data, 8'h32);
    cyc(1);
    chk("col_new", fill_data, 8'hBB);
    cyc(2);
    req = 1'b1; req_addr = 4'd3;
    cyc(1);
    req = 1'b0;
    cyc(6);
    chk("col_later_idx", fill_idx, 2'd2);
    chk("col_later", fill_data, 8'hAA);
    cyc(3);

    // Reset after two fill words; no we may follow.
    req = 1'b1; req_addr = 4'd9;
    cyc(1);
    req = 1'b0;
    cyc(5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", fill_valid, 1'b0);
    chk("mid_rst_state", state, 4'b0001);
    chk("mid_rst_busy", busy, 1'b0);
    cyc(1);
    rst = 1'b0;
    wecnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (we) wecnt++;
    end
    chk("mid_rst_no_we", wecnt, 0);

    // Top line address: no carry into line 0, index wraps afterwards.
    req = 1'b1; req_addr = 4'd15;
    cyc(1);
    req = 1'b0;
    cyc(4);
    for (int i = 0; i < LW; i++) begin
      chk("top_idx", fill_idx, 32'(i));
      chk("top_data", fill_data, 32'hF0 + 32'(i));
      cyc(1);
    end
    chk("top_we", we, 1'b1);
    cyc(1);
    chk("top_idx_wrap", fill_idx, 2'd0);
    chk("top_idle", state, 4'b0001);

    // Random requests and write traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req      = ($urandom_range(0, 3) == 0);
      req_addr = AW'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = (AW+IW)'($urandom_range(0, 63));
      wr_data  = WW'($urandom_range(0, 255));
      cyc(1);
    end
    req = 1'b0; wr_en = 1'b0;
    cyc(12);
    chk("end_idle", state, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
